// File: rtl/reset_gen.sv
// Reset source generator: merges external, software and watchdog reset sources
// into one stretched reset and releases core before peripherals.
module reset_gen #(
  parameter int STRETCH_CYCLES = 16,
  parameter int SEQ_GAP        = 4,
  parameter int WDT_W          = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_soft_rst,
  input  logic             i_wdt_en,
  input  logic             i_wdt_kick,
  input  logic [WDT_W-1:0] i_wdt_limit,
  output logic             o_rst_core,
  output logic             o_rst_periph,
  output logic [1:0]       o_cause,
  output logic             o_busy
);

  localparam int MAXC = (STRETCH_CYCLES > SEQ_GAP) ? STRETCH_CYCLES : SEQ_GAP;
  localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {HOLD, GAP, RUN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WDT_W-1:0] wdt_cnt, wdt_nxt;
  logic [1:0]       cause_nxt;
  logic             wdt_active, wdt_timeout, trigger;

  // The >= compare makes a limit lowered below the running count fire at once.
  assign wdt_active  = (state == RUN) && i_wdt_en && (i_wdt_limit != '0);
  assign wdt_timeout = wdt_active && (wdt_cnt >= i_wdt_limit) && !i_wdt_kick;
  assign trigger     = i_soft_rst || wdt_timeout;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cause_nxt = o_cause;
    if (trigger) begin
      state_nxt = HOLD;
      cnt_nxt   = '0;
      cause_nxt = wdt_timeout ? 2'b11 : 2'b10;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == CW'(STRETCH_CYCLES - 1)) begin
            state_nxt = GAP;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == CW'(SEQ_GAP - 1)) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        RUN:     cnt_nxt = '0;
        default: begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Watchdog saturates at the limit instead of wrapping.
  always_comb begin
    wdt_nxt = wdt_cnt;
    if (!wdt_active || i_wdt_kick) begin
      wdt_nxt = '0;
    end else if (wdt_cnt < i_wdt_limit) begin
      wdt_nxt = wdt_cnt + WDT_W'(1);
    end
  end

  // Outputs are flops fed from the next state so they cannot glitch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= HOLD;
      cnt          <= '0;
      wdt_cnt      <= '0;
      o_cause      <= 2'b01;
      o_rst_core   <= 1'b1;
      o_rst_periph <= 1'b1;
      o_busy       <= 1'b1;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      wdt_cnt      <= wdt_nxt;
      o_cause      <= cause_nxt;
      o_rst_core   <= (state_nxt == HOLD);
      o_rst_periph <= (state_nxt != RUN);
      o_busy       <= (state_nxt != RUN);
    end
  end

endmodule

// File: tb/tb_reset_gen.sv
// Self-checking bench for reset_gen: directed scenarios with literal expectations
// plus randomized stimulus compared every cycle against a timing model.
module tb_reset_gen;

  localparam int S     = 16;
  localparam int G     = 4;
  localparam int WDT_W = 24;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_soft_rst = 1'b0;
  logic             i_wdt_en = 1'b0;
  logic             i_wdt_kick = 1'b0;
  logic [WDT_W-1:0] i_wdt_limit = '0;
  logic             o_rst_core, o_rst_periph, o_busy;
  logic [1:0]       o_cause;

  int checks = 0;
  int errors = 0;

  reset_gen #(.STRETCH_CYCLES(S), .SEQ_GAP(G), .WDT_W(WDT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_soft_rst(i_soft_rst),
    .i_wdt_en(i_wdt_en), .i_wdt_kick(i_wdt_kick), .i_wdt_limit(i_wdt_limit),
    .o_rst_core(o_rst_core), .o_rst_periph(o_rst_periph),
    .o_cause(o_cause), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Model: k counts edges since the stretch began; outputs follow from k alone.
  int k = 0;
  int cause_m = 1;
  int w = 0;
  bit m_run, m_wdt_on, m_wdt_fire;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      k = 0;
      cause_m = 1;
      w = 0;
    end else begin
      m_run      = (k >= S + G);
      m_wdt_on   = m_run && i_wdt_en && (i_wdt_limit != 0);
      m_wdt_fire = m_wdt_on && (w >= int'(i_wdt_limit)) && !i_wdt_kick;
      if (m_wdt_fire || i_soft_rst) begin
        k = 0;
        cause_m = m_wdt_fire ? 3 : 2;
      end else if (k < 1000) begin
        k++;
      end
      if (!m_wdt_on || i_wdt_kick) w = 0;
      else if (w < int'(i_wdt_limit)) w++;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge i_clk) begin
    checkOutput("model_core", int'(o_rst_core), int'(k < S));
    checkOutput("model_periph", int'(o_rst_periph), int'(k < S + G));
    checkOutput("model_busy", int'(o_busy), int'(k < S + G));
    checkOutput("model_cause", int'(o_cause), cause_m);
  end

  // Advance n rising edges and leave inputs/samples just past the falling edge.
  task automatic applyStimulus(input int n);
    repeat (n) @(negedge i_clk);
    #1;
  endtask

  initial begin
    applyStimulus(3);
    checkOutput("por_core_in_reset", int'(o_rst_core), 1);
    checkOutput("por_cause", int'(o_cause), 1);
    i_rst = 1'b0;
    applyStimulus(15);
    checkOutput("por_core_edge15", int'(o_rst_core), 1);
    applyStimulus(1);
    checkOutput("por_core_edge16", int'(o_rst_core), 0);
    checkOutput("por_periph_edge16", int'(o_rst_periph), 1);
    applyStimulus(3);
    checkOutput("por_periph_edge19", int'(o_rst_periph), 1);
    applyStimulus(1);
    checkOutput("por_periph_edge20", int'(o_rst_periph), 0);
    checkOutput("por_busy_edge20", int'(o_busy), 0);
    checkOutput("por_cause_run", int'(o_cause), 1);

    i_soft_rst = 1'b1;
    applyStimulus(1);
    i_soft_rst = 1'b0;
    checkOutput("soft_core", int'(o_rst_core), 1);
    checkOutput("soft_cause", int'(o_cause), 2);
    applyStimulus(15);
    checkOutput("soft_core_15", int'(o_rst_core), 1);
    applyStimulus(1);
    checkOutput("soft_core_16", int'(o_rst_core), 0);
    applyStimulus(3);
    checkOutput("soft_periph_19", int'(o_rst_periph), 1);
    applyStimulus(1);
    checkOutput("soft_periph_20", int'(o_rst_periph), 0);

    i_wdt_en = 1'b1;
    i_wdt_limit = 5;
    applyStimulus(5);
    checkOutput("wdt_quiet_5", int'(o_rst_core), 0);
    applyStimulus(1);
    checkOutput("wdt_fire_6", int'(o_rst_core), 1);
    checkOutput("wdt_cause", int'(o_cause), 3);
    applyStimulus(20);
    for (int i = 0; i < 25; i++) begin
      i_wdt_kick = 1'b1;
      applyStimulus(1);
      i_wdt_kick = 1'b0;
      applyStimulus(3);
    end
    checkOutput("wdt_kicked_100", int'(o_rst_core), 0);

    i_wdt_kick = 1'b1;
    applyStimulus(1);
    i_wdt_kick = 1'b0;
    applyStimulus(5);
    i_wdt_kick = 1'b1;
    applyStimulus(1);
    i_wdt_kick = 1'b0;
    checkOutput("race_kick_at_limit", int'(o_rst_core), 0);
    applyStimulus(5);
    i_soft_rst = 1'b1;
    applyStimulus(1);
    i_soft_rst = 1'b0;
    i_wdt_en = 1'b0;
    checkOutput("race_soft_wdt_core", int'(o_rst_core), 1);
    checkOutput("race_soft_wdt_cause", int'(o_cause), 3);
    applyStimulus(20);

    i_soft_rst = 1'b1;
    applyStimulus(10);
    i_soft_rst = 1'b0;
    applyStimulus(15);
    checkOutput("held_core_15", int'(o_rst_core), 1);
    applyStimulus(1);
    checkOutput("held_core_16", int'(o_rst_core), 0);
    applyStimulus(4);

    i_soft_rst = 1'b1;
    applyStimulus(1);
    i_soft_rst = 1'b0;
    applyStimulus(17);
    checkOutput("gap_core_low", int'(o_rst_core), 0);
    i_soft_rst = 1'b1;
    applyStimulus(1);
    i_soft_rst = 1'b0;
    checkOutput("gap_core_reassert", int'(o_rst_core), 1);
    applyStimulus(15);
    checkOutput("gap_restart_15", int'(o_rst_core), 1);
    applyStimulus(1);
    checkOutput("gap_restart_16", int'(o_rst_core), 0);
    applyStimulus(4);
    checkOutput("gap_restart_periph", int'(o_rst_periph), 0);

    i_soft_rst = 1'b1;
    applyStimulus(1);
    i_soft_rst = 1'b0;
    applyStimulus(5);
    i_rst = 1'b1;
    #1;
    checkOutput("hold_rst_core", int'(o_rst_core), 1);
    checkOutput("hold_rst_cause", int'(o_cause), 1);
    applyStimulus(1);
    i_rst = 1'b0;
    applyStimulus(15);
    checkOutput("hold_rst_core_15", int'(o_rst_core), 1);
    applyStimulus(1);
    checkOutput("hold_rst_core_16", int'(o_rst_core), 0);
    applyStimulus(4);

    i_wdt_en = 1'b1;
    i_wdt_limit = 0;
    applyStimulus(1000);
    checkOutput("limit0_quiet", int'(o_rst_core), 0);
    i_wdt_limit = 5;
    applyStimulus(4);
    i_wdt_en = 1'b0;
    applyStimulus(1);
    i_wdt_en = 1'b1;
    applyStimulus(5);
    checkOutput("en_toggle_quiet_5", int'(o_rst_core), 0);
    applyStimulus(1);
    checkOutput("en_toggle_fire_6", int'(o_rst_core), 1);
    applyStimulus(20);

    for (int i = 0; i < 3000; i++) begin
      i_soft_rst = ($urandom_range(0, 63) == 0);
      i_wdt_kick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 31) == 0) i_wdt_en = ~i_wdt_en;
      if ($urandom_range(0, 63) == 0) i_wdt_limit = WDT_W'($urandom_range(0, 12));
      i_rst = ($urandom_range(0, 499) == 0);
      applyStimulus(1);
    end
    i_rst = 1'b0;
    i_soft_rst = 1'b0;
    applyStimulus(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_gen.md
# reset_gen

Reset source generator that sits directly upstream of the per-domain reset synchronizers. It merges the external asynchronous reset, a software reset request and a watchdog timeout into one stretched reset. It releases that reset in two ordered stages: core first, peripherals later. Both outputs are registered and glitch-free, and are intended to drive the asynchronous reset inputs of downstream reset synchronizers. It also records which source caused the last reset.

## Interface
Parameters:
- STRETCH_CYCLES, 16, cycles both outputs stay asserted after any reset source ends (≥2)
- SEQ_GAP, 4, cycles between o_rst_core release and o_rst_periph release (≥1)
- WDT_W, 24, watchdog counter/limit width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_soft_rst  in  1  software reset request, synchronous to i_clk, sampled every edge
- i_wdt_en  in  1  watchdog enable, synchronous level
- i_wdt_kick  in  1  watchdog service pulse, synchronous
- i_wdt_limit  in  WDT_W  watchdog timeout count; 0 = watchdog never fires
- o_rst_core  out  1  core-domain reset source, active-high, registered
- o_rst_periph  out  1  peripheral-domain reset source, active-high, registered
- o_cause  out  2  last reset cause: 01 external, 10 soft, 11 watchdog
- o_busy  out  1  high while in any state other than RUN

## Operation
- FSM states:
  - HOLD: both resets high.
  - GAP: core low, periph high.
  - RUN: both low.
- Outputs are decoded from registered state; no combinational path from any input to o_rst_*.
- i_rst high (async) forces:
  - state to HOLD, stretch counter to 0, wdt counter to 0;
  - o_rst_core = 1, o_rst_periph = 1, o_cause = 01, o_busy = 1.
- HOLD:
  - The stretch counter increments each edge.
  - At the edge where counter == STRETCH_CYCLES-1, go to GAP and clear the counter.
- GAP:
  - The counter increments.
  - At counter == SEQ_GAP-1, go to RUN.
- Trigger = i_soft_rst OR wdt_timeout, sampled at an edge in any state.
  - Effect: go to HOLD, clear the stretch counter, latch o_cause.
  - A trigger in HOLD restarts the stretch.
  - A trigger in GAP re-asserts o_rst_core.
- Simultaneous soft and watchdog trigger: o_cause = 11 (watchdog wins).
- A continuously held i_soft_rst keeps the block in HOLD; the stretch begins from the first edge where it is low.
- o_cause holds its value through GAP/RUN until the next trigger or i_rst.
- Watchdog counter:
  - Counts only in RUN with i_wdt_en = 1 and i_wdt_limit != 0.
  - Clears on i_wdt_kick, on i_wdt_en = 0, and in any non-RUN state.
  - wdt_timeout = (cnt == i_wdt_limit) AND no kick that edge; a kick coincident with the limit wins and no reset occurs.
  - The counter must not wrap: it saturates at limit, firing immediately.
  - A change of i_wdt_limit below the current count fires at the next edge (cnt ≥ limit compares as timeout).

## Timing
- After i_rst falls:
  - o_rst_core drops after exactly STRETCH_CYCLES rising edges.
  - o_rst_periph drops SEQ_GAP edges later.
  - o_busy drops with o_rst_periph.
- A trigger sampled at edge N drives o_rst_core/o_rst_periph high from edge N (visible in cycle N+1).
  - Core is released at edge N+STRETCH_CYCLES.
  - Periph is released at N+STRETCH_CYCLES+SEQ_GAP.
- Watchdog with limit L, enabled from RUN entry, no kicks: fires at the (L+1)-th edge in RUN.
- Assertion of i_rst at any time is immediate (asynchronous); deassertion is handled by downstream synchronizers.

## Test plan
- **Power-on:** i_rst high 3 cycles, then low, defaults (16/4).
  - o_rst_core low after 16 edges; o_rst_periph low after 20 edges.
  - o_cause = 01 throughout.
- **Soft reset:** in RUN, 1-cycle i_soft_rst.
  - Both resets high next cycle for 16 cycles; periph released 4 cycles after core.
  - o_cause = 10.
- **Watchdog:** i_wdt_limit = 5, i_wdt_en = 1, no kicks.
  - Resets assert after 6th RUN edge; o_cause = 11.
  - Repeat with a kick every 4 cycles: no reset for 100 cycles.
- **Races:**
  - Kick on the same edge cnt == limit: no reset.
  - Soft and watchdog on the same edge: o_cause = 11.
  - Soft held 10 cycles: core released 16 edges after the fall.
- **Mid-sequence:**
  - i_soft_rst during GAP: o_rst_core re-asserts, full 16+4 sequence restarts.
  - i_rst pulse mid-HOLD: outputs stay high, o_cause = 01, counter restarts.
- **Limit 0 / disable:**
  - i_wdt_limit = 0 for 1000 cycles: no reset.
  - i_wdt_en toggled low resets the count (limit 5, en low at count 4, re-enabled): fires 6 edges after re-enable.
